// File: rtl/microseq_pkg.sv
// Shared encodings and widths for the microsequencer.
package microseq_pkg;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned WCNT_W = 8;

  typedef enum logic [2:0] {
    NS_INC     = 3'b000,
    NS_JUMP    = 3'b001,
    NS_DECODE  = 3'b010,
    NS_CJUMP   = 3'b011,
    NS_WAIT    = 3'b100,
    NS_CALL    = 3'b101,
    NS_RETURN  = 3'b110,
    NS_RESTART = 3'b111
  } ns_mode_e;

  typedef enum logic [1:0] {
    CS_COND_TRUE = 2'b00,
    CS_MOC       = 2'b01,
    CS_ONE       = 2'b10,
    CS_ZERO      = 2'b11
  } cond_sel_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } seq_state_e;

endpackage

// File: rtl/microseq_cond_mux.sv
// Branch condition select with optional inversion (purely combinational).
module microseq_cond_mux (
  input  logic [1:0] cond_sel_i,
  input  logic       inv_i,
  input  logic       cond_true_i,
  input  logic       moc_i,
  output logic       cond_c_o
);
  import microseq_pkg::*;

  logic sel_c;

  always_comb begin
    sel_c = 1'b0;
    case (cond_sel_e'(cond_sel_i))
      CS_COND_TRUE: sel_c = cond_true_i;
      CS_MOC:       sel_c = moc_i;
      CS_ONE:       sel_c = 1'b1;
      CS_ZERO:      sel_c = 1'b0;
      default:      sel_c = 1'b0;
    endcase
  end

  assign cond_c_o = sel_c ^ inv_i;

endmodule

// File: rtl/microsequencer.sv
// Microstore address sequencer with single-level call/return and WAIT state.
// Optional wait timeout to FAULT_ADDR is enabled by defining MICROSEQ_TIMEOUT_EN.
module microsequencer #(
  parameter int unsigned       ADDR_W         = microseq_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_ADDR     = '0,
  parameter logic [ADDR_W-1:0] FAULT_ADDR     = ADDR_W'(45),
  parameter int unsigned       TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        ns_ctrl,
  input  logic [1:0]        cond_sel,
  input  logic              inv,
  input  logic [ADDR_W-1:0] cr_addr,
  input  logic [ADDR_W-1:0] dec_addr,
  input  logic              cond_true,
  input  logic              moc,
  input  logic              hold,
  output logic [ADDR_W-1:0] index,
  output logic              waiting,
  output logic              fault
);
  import microseq_pkg::*;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("microsequencer: TIMEOUT_CYCLES must be within 1..255");
  end

  ns_mode_e          mode;
  seq_state_e        state_q;
  logic [ADDR_W-1:0] index_q;
  logic [ADDR_W-1:0] ret_addr_q;
  logic              ret_valid_q;
  logic [ADDR_W-1:0] inc_addr;
  logic              cond;
  logic              timeout;

  assign mode     = ns_mode_e'(ns_ctrl);
  assign inc_addr = index_q + ADDR_W'(1);

  microseq_cond_mux u_cond_mux (
    .cond_sel_i  (cond_sel),
    .inv_i       (inv),
    .cond_true_i (cond_true),
    .moc_i       (moc),
    .cond_c_o    (cond)
  );

`ifdef MICROSEQ_TIMEOUT_EN
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT_CYCLES - 1);

  logic [WCNT_W-1:0] wcnt_q;
  logic              fault_q;

  // Expiry only matters while still waiting on a false condition.
  assign timeout = (state_q == ST_WAIT) && (mode == NS_WAIT) && !cond &&
                   (wcnt_q == WCNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt_q  <= '0;
      fault_q <= 1'b0;
    end else if (hold) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= timeout;
      if ((state_q == ST_WAIT) && (mode == NS_WAIT) && !cond && !timeout)
        wcnt_q <= wcnt_q + WCNT_W'(1);
      else
        wcnt_q <= '0;
    end
  end

  assign fault = fault_q;
`else
  assign timeout = 1'b0;
  assign fault   = 1'b0;
`endif

  // Sequencer FSM: index, return register and RUN/WAIT state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      index_q     <= RESET_ADDR;
      ret_addr_q  <= '0;
      ret_valid_q <= 1'b0;
    end else if (!hold) begin
      state_q <= ST_RUN;
      case (mode)
        NS_INC:    index_q <= inc_addr;
        NS_JUMP:   index_q <= cr_addr;
        NS_DECODE: index_q <= dec_addr;
        NS_CJUMP:  index_q <= cond ? cr_addr : inc_addr;
        NS_WAIT: begin
          if (cond) begin
            index_q <= inc_addr;
          end else if (timeout) begin
            index_q <= FAULT_ADDR;
          end else begin
            state_q <= ST_WAIT;
          end
        end
        NS_CALL: begin
          ret_addr_q  <= inc_addr;
          ret_valid_q <= 1'b1;
          index_q     <= cr_addr;
        end
        NS_RETURN: begin
          index_q     <= ret_valid_q ? ret_addr_q : RESET_ADDR;
          ret_valid_q <= 1'b0;
        end
        NS_RESTART: begin
          index_q     <= RESET_ADDR;
          ret_valid_q <= 1'b0;
        end
        default: index_q <= RESET_ADDR;
      endcase
    end
  end

  assign index   = index_q;
  assign waiting = (state_q == ST_WAIT);

endmodule

// File: tb/tb_microsequencer.sv
// Randomized and directed check of microsequencer against a behavioural model.
module tb_microsequencer;

  localparam int TMO = 3;
`ifdef MICROSEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] ns_ctrl = 3'd0;
  logic [1:0] cond_sel = 2'd0;
  logic       inv = 1'b0;
  logic [5:0] cr_addr = 6'd0;
  logic [5:0] dec_addr = 6'd0;
  logic       cond_true = 1'b0;
  logic       moc = 1'b0;
  logic       hold = 1'b0;
  logic [5:0] index;
  logic       waiting;
  logic       fault;

  int total = 0;
  int bad = 0;
  bit check_en = 1'b0;

  microsequencer #(
    .ADDR_W(6), .RESET_ADDR(6'd0), .FAULT_ADDR(6'd45), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .ns_ctrl(ns_ctrl), .cond_sel(cond_sel), .inv(inv),
    .cr_addr(cr_addr), .dec_addr(dec_addr), .cond_true(cond_true), .moc(moc),
    .hold(hold), .index(index), .waiting(waiting), .fault(fault)
  );

  always #5 clk = ~clk;

  // Selected condition: table lookup {0, 1, moc, cond_true} indexed by sel.
  function automatic logic cond_of(input logic [1:0] s, input logic iv,
                                   input logic ct, input logic mc);
    logic [3:0] tbl;
    tbl = {1'b0, 1'b1, mc, ct};
    return tbl[s] ^ iv;
  endfunction

  // Behavioural model: m_waitn counts consecutive cycles spent waiting.
  int m_idx = 0, m_ret = 0, m_waitn = 0;
  bit m_rv = 1'b0, m_fault = 1'b0;

  always @(posedge clk) begin : model
    int nxt, nw;
    logic c;
    nxt = (m_idx + 1) % 64;
    c = cond_of(cond_sel, inv, cond_true, moc);
    if (reset) begin
      m_idx = 0; m_ret = 0; m_rv = 1'b0; m_waitn = 0; m_fault = 1'b0;
    end else if (hold) begin
      m_fault = 1'b0;
    end else begin
      m_fault = 1'b0;
      nw = 0;
      case (ns_ctrl)
        3'd0: m_idx = nxt;
        3'd1: m_idx = int'(cr_addr);
        3'd2: m_idx = int'(dec_addr);
        3'd3: m_idx = c ? int'(cr_addr) : nxt;
        3'd4: begin
          if (c) m_idx = nxt;
          else if (TO_EN && m_waitn == TMO) begin m_idx = 45; m_fault = 1'b1; end
          else nw = m_waitn + 1;
        end
        3'd5: begin m_ret = nxt; m_rv = 1'b1; m_idx = int'(cr_addr); end
        3'd6: begin m_idx = m_rv ? m_ret : 0; m_rv = 1'b0; end
        default: begin m_idx = 0; m_rv = 1'b0; end
      endcase
      m_waitn = nw;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      total++;
      if (index !== 6'(m_idx)) begin
        bad++;
        $display("FAIL model_index t=%0t got=%0d exp=%0d", $time, index, m_idx);
      end
      total++;
      if (waiting !== (m_waitn > 0)) begin
        bad++;
        $display("FAIL model_waiting t=%0t got=%b exp=%b", $time, waiting, m_waitn > 0);
      end
      total++;
      if (fault !== m_fault) begin
        bad++;
        $display("FAIL model_fault t=%0t got=%b exp=%b", $time, fault, m_fault);
      end
    end
  end

  task automatic step(input logic [2:0] m, input logic [1:0] s, input logic iv,
                      input logic [5:0] cr, input logic ct, input logic mc,
                      input logic h, input logic r);
    @(negedge clk);
    ns_ctrl = m; cond_sel = s; inv = iv; cr_addr = cr;
    cond_true = ct; moc = mc; hold = h; reset = r;
    @(posedge clk);
    #2;
  endtask

  task automatic lit(input string name, input int e_idx, input bit e_wait, input bit e_fault);
    total++;
    if (index !== 6'(e_idx) || waiting !== e_wait || fault !== e_fault) begin
      bad++;
      $display("FAIL %s got idx=%0d wait=%b fault=%b exp idx=%0d wait=%b fault=%b",
               name, index, waiting, fault, e_idx, e_wait, e_fault);
    end
  endtask

  task automatic jump(input logic [5:0] a);
    step(3'd1, 2'd0, 1'b0, a, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int nlow;
    step(3'd0, 2'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_en = 1'b1;
    lit("reset", 0, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      step(3'd0, 2'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      lit("inc", i, 1'b0, 1'b0);
    end

    jump(6'd8); step(3'd3, 2'd0, 1'b0, 6'd28, 1'b1, 1'b0, 1'b0, 1'b0); lit("cjump_t", 28, 1'b0, 1'b0);
    jump(6'd8); step(3'd3, 2'd0, 1'b0, 6'd28, 1'b0, 1'b0, 1'b0, 1'b0); lit("cjump_f", 9, 1'b0, 1'b0);
    jump(6'd8); step(3'd3, 2'd0, 1'b1, 6'd28, 1'b1, 1'b0, 1'b0, 1'b0); lit("cjump_inv_t", 9, 1'b0, 1'b0);
    jump(6'd8); step(3'd3, 2'd0, 1'b1, 6'd28, 1'b0, 1'b0, 1'b0, 1'b0); lit("cjump_inv_f", 28, 1'b0, 1'b0);

    nlow = TO_EN ? 2 : 4;
    jump(6'd10);
    for (int i = 0; i < nlow; i++) begin
      step(3'd4, 2'd1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      lit("wait_hold", 10, 1'b1, 1'b0);
    end
    step(3'd4, 2'd1, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    lit("wait_exit", 11, 1'b0, 1'b0);

    if (TO_EN) begin
      jump(6'd20);
      for (int i = 0; i < TMO; i++) begin
        step(3'd4, 2'd1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        lit("tmo_wait", 20, 1'b1, 1'b0);
      end
      step(3'd4, 2'd1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      lit("tmo_fault", 45, 1'b0, 1'b1);
      step(3'd0, 2'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      lit("tmo_pulse_end", 46, 1'b0, 1'b0);
      jump(6'd20);
      for (int i = 0; i < TMO; i++) step(3'd4, 2'd1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(3'd4, 2'd1, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      lit("tmo_race_exit", 21, 1'b0, 1'b0);
    end

    jump(6'd5);
    step(3'd5, 2'd0, 1'b0, 6'd32, 1'b0, 1'b0, 1'b0, 1'b0); lit("call", 32, 1'b0, 1'b0);
    step(3'd6, 2'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);  lit("return", 6, 1'b0, 1'b0);
    step(3'd6, 2'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);  lit("return_empty", 0, 1'b0, 1'b0);

    jump(6'd63);
    step(3'd0, 2'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0); lit("inc_wrap", 0, 1'b0, 1'b0);
    step(3'd0, 2'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0); lit("hold1", 0, 1'b0, 1'b0);
    step(3'd1, 2'd0, 1'b0, 6'd9, 1'b0, 1'b0, 1'b1, 1'b0); lit("hold2", 0, 1'b0, 1'b0);
    step(3'd0, 2'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0); lit("hold_release", 1, 1'b0, 1'b0);

    dec_addr = 6'd17;
    step(3'd2, 2'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0); lit("decode", 17, 1'b0, 1'b0);
    step(3'd7, 2'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0); lit("restart", 0, 1'b0, 1'b0);

    jump(6'd10);
    step(3'd4, 2'd1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0); lit("pre_reset_wait", 10, 1'b1, 1'b0);
    step(3'd4, 2'd1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b1); lit("reset_over_hold", 0, 1'b0, 1'b0);

    // Random traffic with bursts of WAIT to reach timeouts.
    for (int i = 0; i < 3000; i++) begin
      logic [2:0] m;
      int burst;
      m = 3'($urandom_range(0, 7));
      burst = (m == 3'd4) ? $urandom_range(1, 7) : 1;
      dec_addr = 6'($urandom);
      for (int k = 0; k < burst; k++) begin
        step(m, 2'($urandom), 1'($urandom), 6'($urandom),
             1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
             1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 99) == 0));
      end
    end

    @(negedge clk);
    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
